stream_packet_arbiter: RTL

- Shares one byte-stream datapath (e.g. a stream normalizer input) between NUM_IN packet sources.
- Uses round-robin arbitration at packet granularity. The grant is held from the first presented beat until the beat with last is accepted, so packets never interleave.
- All ports use the team's byte-stream format: data, cnt, last, valid/ready. cnt==0 means all DATA_BYTES are valid; on non-last beats, cnt must be 0.

---
 rtl/stream_packet_arbiter_pkg.sv | 26 ++
 rtl/stream_packet_arbiter_if.sv | 33 +++
 rtl/stream_packet_arbiter_skid_buffer.sv | 45 ++++
 rtl/stream_packet_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/stream_packet_arbiter_pkg.sv
// Shared types and the round-robin search used by the packet arbiter.
// The search is sized for up to RR_MAX requesters.
package stream_pkg;

   localparam int RR_MAX = 16;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

   // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none is set.
   function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                          input logic [3:0]        ptr,
                                          input int                n);
      logic [3:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < RR_MAX; i++) begin
         idx = 4'((int'(ptr) + i) % n);
         if (i < n && !found && valid[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/stream_packet_arbiter_if.sv
// Byte-stream bundle between NUM_IN packet sources and one shared output.
// slave is the arbiter side, master is the side feeding and draining it.
interface stream_packet_arbiter_if #(
   parameter int DATA_BYTES = 8,
   parameter int NUM_IN     = 4
);
   localparam int DATA_BITS = DATA_BYTES * 8;
   localparam int CNT_BITS  = $clog2(DATA_BYTES);
   localparam int SEL_BITS  = $clog2(NUM_IN);

   logic [NUM_IN*DATA_BITS-1:0] in_data;
   logic [NUM_IN*CNT_BITS-1:0]  in_cnt;
   logic [NUM_IN-1:0]           in_last;
   logic [NUM_IN-1:0]           in_valid;
   logic [NUM_IN-1:0]           in_ready;
   logic [DATA_BITS-1:0]        out_data;
   logic [CNT_BITS-1:0]         out_cnt;
   logic                        out_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [SEL_BITS-1:0]         out_sel;
   logic                        busy;

   modport slave (
      input  in_data, in_cnt, in_last, in_valid, out_ready,
      output in_ready, out_data, out_cnt, out_last, out_valid, out_sel, busy
   );

   modport master (
      output in_data, in_cnt, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_cnt, out_last, out_valid, out_sel, busy
   );
endinterface

// File: rtl/stream_packet_arbiter_skid_buffer.sv
// Two-entry valid/ready register slice: 1-cycle latency, full throughput.
// in_rdy is registered (skid slot empty), so out_rdy never reaches in_rdy combinationally.
module stream_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat
);
   logic             main_vld;
   logic [WIDTH-1:0] main_dat;
   logic             skid_vld;
   logic [WIDTH-1:0] skid_dat;

   assign in_rdy  = !skid_vld;
   assign out_vld = main_vld;
   assign out_dat = main_dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld <= 1'b0;
         main_dat <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (!main_vld || out_rdy) begin
         // Output slot is free this cycle: refill from the skid slot first to keep order.
         if (skid_vld) begin
            main_dat <= skid_dat;
            main_vld <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            main_dat <= in_dat;
            main_vld <= in_vld;
         end
      end else if (in_vld && !skid_vld) begin
         skid_dat <= in_dat;
         skid_vld <= 1'b1;
      end
   end
endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter onto one byte stream; 0-cycle mux, or 1 cycle with STREAM_PACKET_ARBITER_OUT_REG_EN.
// Only the selected requester sees ready; the grant holds until its last beat transfers.
module stream_packet_arbiter
   import stream_pkg::*;
#(
   parameter int DATA_BYTES = 8,
   parameter int NUM_IN     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   stream_packet_arbiter_if.slave  bus
);
   localparam int DATA_BITS = DATA_BYTES * 8;
   localparam int CNT_BITS  = $clog2(DATA_BYTES);
   localparam int SEL_BITS  = $clog2(NUM_IN);

   arb_state_e            state;
   logic [SEL_BITS-1:0]   grant;
   logic [SEL_BITS-1:0]   ptr;
   logic                  busy_q;
   logic [SEL_BITS-1:0]   pick;
   logic [SEL_BITS-1:0]   cur;
   logic [SEL_BITS-1:0]   nxt;
   logic [DATA_BITS-1:0]  mux_dat;
   logic [CNT_BITS-1:0]   mux_cnt;
   logic                  mux_last;
   logic                  mux_vld;
   logic                  arb_rdy;
   logic                  hs;

   assign pick = SEL_BITS'(rr_pick(16'(bus.in_valid), 4'(ptr), NUM_IN));
   assign cur  = (state == ARB_LOCKED) ? grant : pick;
   assign nxt  = (cur == SEL_BITS'(NUM_IN - 1)) ? '0 : cur + SEL_BITS'(1);

   always_comb begin
      mux_dat  = '0;
      mux_cnt  = '0;
      mux_last = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (SEL_BITS'(i) == cur) begin
            mux_dat  = bus.in_data[i*DATA_BITS +: DATA_BITS];
            mux_cnt  = bus.in_cnt[i*CNT_BITS +: CNT_BITS];
            mux_last = bus.in_last[i];
         end
      end
   end

   assign mux_vld = rst_n && ((state == ARB_LOCKED) ? bus.in_valid[cur] : |bus.in_valid);
   assign hs      = mux_vld && arb_rdy;

   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (rst_n && SEL_BITS'(i) == cur) begin
            bus.in_ready[i] = arb_rdy;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         ptr    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (hs && mux_last) begin
                  ptr <= nxt;
               end else if (mux_vld) begin
                  // Lock on a stalled beat too, so the presented beat cannot change under backpressure.
                  state  <= ARB_LOCKED;
                  grant  <= cur;
                  busy_q <= 1'b1;
               end
            end
            ARB_LOCKED: begin
               if (hs && mux_last) begin
                  state  <= ARB_IDLE;
                  ptr    <= nxt;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;

`ifdef STREAM_PACKET_ARBITER_OUT_REG_EN
   localparam int SKID_W = DATA_BITS + CNT_BITS + 1 + SEL_BITS;

   logic              skid_rdy;
   logic [SKID_W-1:0] skid_out;

   stream_skid_buffer #(.WIDTH(SKID_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (mux_vld),
      .in_rdy  (skid_rdy),
      .in_dat  ({mux_dat, mux_cnt, mux_last, cur}),
      .out_vld (bus.out_valid),
      .out_rdy (bus.out_ready),
      .out_dat (skid_out)
   );

   assign arb_rdy = skid_rdy;
   assign {bus.out_data, bus.out_cnt, bus.out_last, bus.out_sel} = skid_out;
`else
   assign arb_rdy       = bus.out_ready;
   assign bus.out_data  = mux_dat;
   assign bus.out_cnt   = mux_cnt;
   assign bus.out_last  = mux_last;
   assign bus.out_valid = mux_vld;
   assign bus.out_sel   = rst_n ? cur : '0;
`endif
endmodule
